// File: rtl/conv_job_arbiter.sv
// rtl/conv_job_arbiter.sv - round-robin job arbiter sharing one convolution engine between requesters
module conv_job_arbiter #(
  parameter int NREQ = 2,
  parameter int M    = 112,
  parameter int N    = 49,
  parameter int XW   = 10,
  parameter int YW   = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  input  logic [NREQ*XW-1:0]   rq_x_data,
  input  logic [NREQ-1:0]      rq_x_valid,
  output logic [NREQ-1:0]      rq_x_ready,
  input  logic [NREQ*XW-1:0]   rq_f_data,
  input  logic [NREQ-1:0]      rq_f_valid,
  output logic [NREQ-1:0]      rq_f_ready,
  output logic [YW-1:0]        rq_y_data,
  output logic [NREQ-1:0]      rq_y_valid,
  input  logic [NREQ-1:0]      rq_y_ready,
  output logic [XW-1:0]        eng_x_data,
  output logic                 eng_x_valid,
  input  logic                 eng_x_ready,
  output logic [XW-1:0]        eng_f_data,
  output logic                 eng_f_valid,
  input  logic                 eng_f_ready,
  input  logic [YW-1:0]        eng_y_data,
  input  logic                 eng_y_valid,
  output logic                 eng_y_ready
);

  localparam int CW = $clog2(M + 1);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] X_LIMIT = CW'(M);
  localparam logic [CW-1:0] F_LIMIT = CW'(N);
  localparam logic [CW-1:0] Y_LAST  = CW'(M - N);

  typedef enum logic [1:0] {IDLE, LOAD, COLLECT} state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   last;
  logic [OW-1:0]   pick;
  logic            any_req;
  logic [CW-1:0]   xcnt;
  logic [CW-1:0]   fcnt;
  logic [CW-1:0]   ycnt;
  logic            x_open;
  logic            f_open;
  logic            x_hs;
  logic            f_hs;
  logic            y_hs;

  assign x_open = (xcnt < X_LIMIT);
  assign f_open = (fcnt < F_LIMIT);
  assign x_hs   = eng_x_valid & eng_x_ready;
  assign f_hs   = eng_f_valid & eng_f_ready;
  assign y_hs   = eng_y_valid & eng_y_ready;

  // Round-robin pick: first requesting index after the previous owner, wrapping.
  always_comb begin
    pick    = last;
    any_req = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!any_req && req[(int'(last) + i) % NREQ]) begin
        any_req = 1'b1;
        pick    = OW'((int'(last) + i) % NREQ);
      end
    end
  end

  // Zero-latency stream steering between the owner and the engine; everything else held at 0.
  always_comb begin
    rq_x_ready  = '0;
    rq_f_ready  = '0;
    rq_y_valid  = '0;
    rq_y_data   = '0;
    eng_x_data  = '0;
    eng_x_valid = 1'b0;
    eng_f_data  = '0;
    eng_f_valid = 1'b0;
    eng_y_ready = 1'b0;
    if (state == LOAD) begin
      eng_x_data        = rq_x_data[int'(owner)*XW +: XW];
      eng_x_valid       = rq_x_valid[owner] & x_open;
      rq_x_ready[owner] = eng_x_ready & x_open;
      eng_f_data        = rq_f_data[int'(owner)*XW +: XW];
      eng_f_valid       = rq_f_valid[owner] & f_open;
      rq_f_ready[owner] = eng_f_ready & f_open;
    end
    if (state == COLLECT) begin
      rq_y_valid[owner] = eng_y_valid;
      eng_y_ready       = rq_y_ready[owner];
      rq_y_data         = eng_y_data;
    end
  end

  // Job FSM: grant, count x/f in, count y out, release with a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      last  <= OW'(NREQ - 1);
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      xcnt  <= '0;
      fcnt  <= '0;
      ycnt  <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= pick;
            gnt   <= NREQ'(1) << pick;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (x_hs) xcnt <= xcnt + 1'b1;
          if (f_hs) fcnt <= fcnt + 1'b1;
          if (!x_open && !f_open) state <= COLLECT;
        end
        COLLECT: begin
          if (y_hs) begin
            if (ycnt == Y_LAST) begin
              done  <= NREQ'(1) << owner;
              last  <= owner;
              gnt   <= '0;
              busy  <= 1'b0;
              xcnt  <= '0;
              fcnt  <= '0;
              ycnt  <= '0;
              state <= IDLE;
            end else begin
              ycnt <= ycnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_job_arbiter.sv
// tb/tb_conv_job_arbiter.sv - directed table-driven bench for conv_job_arbiter
module tb_conv_job_arbiter;

  localparam int NREQ = 2;
  localparam int M    = 112;
  localparam int N    = 49;
  localparam int XW   = 10;
  localparam int YW   = 26;
  localparam int NY   = M - N + 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic                busy;
  logic [NREQ*XW-1:0]  rq_x_data;
  logic [NREQ-1:0]     rq_x_valid;
  logic [NREQ-1:0]     rq_x_ready;
  logic [NREQ*XW-1:0]  rq_f_data;
  logic [NREQ-1:0]     rq_f_valid;
  logic [NREQ-1:0]     rq_f_ready;
  logic [YW-1:0]       rq_y_data;
  logic [NREQ-1:0]     rq_y_valid;
  logic [NREQ-1:0]     rq_y_ready;
  logic [XW-1:0]       eng_x_data;
  logic                eng_x_valid;
  logic                eng_x_ready;
  logic [XW-1:0]       eng_f_data;
  logic                eng_f_valid;
  logic                eng_f_ready;
  logic [YW-1:0]       eng_y_data;
  logic                eng_y_valid;
  logic                eng_y_ready;

  always #5 clk = ~clk;

  conv_job_arbiter #(.NREQ(NREQ), .M(M), .N(N), .XW(XW), .YW(YW)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .done(done), .busy(busy),
    .rq_x_data(rq_x_data), .rq_x_valid(rq_x_valid), .rq_x_ready(rq_x_ready),
    .rq_f_data(rq_f_data), .rq_f_valid(rq_f_valid), .rq_f_ready(rq_f_ready),
    .rq_y_data(rq_y_data), .rq_y_valid(rq_y_valid), .rq_y_ready(rq_y_ready),
    .eng_x_data(eng_x_data), .eng_x_valid(eng_x_valid), .eng_x_ready(eng_x_ready),
    .eng_f_data(eng_f_data), .eng_f_valid(eng_f_valid), .eng_f_ready(eng_f_ready),
    .eng_y_data(eng_y_data), .eng_y_valid(eng_y_valid), .eng_y_ready(eng_y_ready)
  );

  typedef struct {
    logic [NREQ-1:0] req;
    int              owner;
    bit              yrand;
    bit              xrand;
    bit              xextra;
    bit              drop;
  } job_t;

  int   total = 0;
  int   bad   = 0;
  int   ex[M];
  int   ef[N];
  job_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int xv(input int r, input int i);
    return i + 1 + 100 * r;
  endfunction

  function automatic int fv(input int r, input int i);
    return i + 1 + 50 * r;
  endfunction

  function automatic int ygold(input int r, input int k);
    int s = 0;
    for (int j = 0; j < N; j++) s += xv(r, k + j) * fv(r, N - 1 - j);
    return s;
  endfunction

  function automatic int yeng(input int k);
    int s = 0;
    for (int j = 0; j < N; j++) s += ex[k + j] * ef[N - 1 - j];
    return s;
  endfunction

  task automatic run_job(input job_t t);
    int  r, o, xi, fi, yi, cyc;
    bit  exv, efv;
    r = t.owner;
    o = 1 - r;
    req = t.req;
    #1;
    check("idle_gnt", int'(gnt), 0);
    @(posedge clk);
    @(negedge clk);
    check("grant", int'(gnt), 1 << r);
    check("busy_set", int'(busy), 1);
    check("done_clear", int'(done), 0);
    if (t.drop) req = '0;
    xi = 0; fi = 0; cyc = 0;
    while ((xi < M || fi < N) && cyc < 3000) begin
      rq_x_data[r*XW +: XW] = XW'(xv(r, (xi < M) ? xi : 0));
      rq_x_data[o*XW +: XW] = 10'h155;
      rq_f_data[r*XW +: XW] = XW'(fv(r, (fi < N) ? fi : 0));
      rq_f_data[o*XW +: XW] = 10'h0aa;
      rq_x_valid[o] = 1'b1;
      rq_f_valid[o] = 1'b1;
      rq_x_valid[r] = t.xextra ? 1'b1 : ((xi < M) && (t.xrand ? 1'($urandom_range(0, 1)) : 1'b1));
      rq_f_valid[r] = (fi < N) && (t.xextra ? (xi >= M) : (t.xrand ? 1'($urandom_range(0, 1)) : 1'b1));
      eng_x_ready = t.xrand ? 1'($urandom_range(0, 1)) : 1'b1;
      eng_f_ready = t.xrand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      exv = rq_x_valid[r] && (xi < M);
      efv = rq_f_valid[r] && (fi < N);
      check("eng_x_valid", int'(eng_x_valid), int'(exv));
      check("rq_x_ready", int'(rq_x_ready), (eng_x_ready && xi < M) ? (1 << r) : 0);
      check("eng_f_valid", int'(eng_f_valid), int'(efv));
      check("rq_f_ready", int'(rq_f_ready), (eng_f_ready && fi < N) ? (1 << r) : 0);
      check("load_y_valid", int'(rq_y_valid), 0);
      check("load_gnt", int'(gnt), 1 << r);
      if (exv) check("eng_x_data", int'(eng_x_data), xv(r, xi));
      if (efv) check("eng_f_data", int'(eng_f_data), fv(r, fi));
      if (exv && eng_x_ready) begin ex[xi] = int'(eng_x_data); xi++; end
      if (efv && eng_f_ready) begin ef[fi] = int'(eng_f_data); fi++; end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) check("load_timeout", 0, 1);
    // counters full, still in LOAD for this cycle
    rq_x_valid[r] = t.xextra;
    rq_f_valid[r] = 1'b0;
    eng_x_ready = 1'b1;
    eng_f_ready = 1'b1;
    eng_y_valid = 1'b1;
    eng_y_data  = YW'(yeng(0));
    rq_y_ready  = '1;
    #1;
    check("full_x_ready", int'(rq_x_ready), 0);
    check("full_x_valid", int'(eng_x_valid), 0);
    check("full_y_ready", int'(eng_y_ready), 0);
    check("full_y_valid", int'(rq_y_valid), 0);
    @(negedge clk);
    yi = 0; cyc = 0;
    while (yi < NY && cyc < 3000) begin
      eng_y_valid = t.yrand ? 1'($urandom_range(0, 1)) : 1'b1;
      eng_y_data  = YW'(yeng(yi));
      rq_y_ready  = '1;
      rq_y_ready[r] = t.yrand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("rq_y_valid", int'(rq_y_valid), eng_y_valid ? (1 << r) : 0);
      check("eng_y_ready", int'(eng_y_ready), int'(rq_y_ready[r]));
      check("col_done", int'(done), 0);
      check("col_x_valid", int'(eng_x_valid), 0);
      if (eng_y_valid && rq_y_ready[r]) begin
        check("y_data", int'(rq_y_data), ygold(r, yi));
        yi++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) check("collect_timeout", 0, 1);
    eng_y_valid = 1'b0;
    rq_x_valid  = '0;
    rq_f_valid  = '0;
    #1;
    check("done_pulse", int'(done), 1 << r);
    check("end_busy", int'(busy), 0);
    check("end_gnt", int'(gnt), 0);
    check("end_y_ready", int'(eng_y_ready), 0);
  endtask

  initial begin
    //            req    own yr xr xe dr
    tbl[0] = '{2'b11, 0, 0, 0, 0, 0};
    tbl[1] = '{2'b11, 1, 0, 0, 0, 0};
    tbl[2] = '{2'b11, 0, 0, 0, 0, 0};
    tbl[3] = '{2'b11, 1, 0, 0, 0, 0};
    tbl[4] = '{2'b01, 0, 1, 0, 0, 0};
    tbl[5] = '{2'b10, 1, 0, 0, 1, 0};
    tbl[6] = '{2'b10, 1, 0, 0, 0, 1};
    tbl[7] = '{2'b01, 0, 1, 1, 0, 1};

    reset = 1'b1;
    req = '0;
    rq_x_data = '1;
    rq_f_data = '1;
    rq_x_valid = '1;
    rq_f_valid = '1;
    rq_y_ready = '1;
    eng_x_ready = 1'b1;
    eng_f_ready = 1'b1;
    eng_y_valid = 1'b1;
    eng_y_data = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_x_ready", int'(rq_x_ready), 0);
    check("rst_eng_x_valid", int'(eng_x_valid), 0);
    check("rst_eng_x_data", int'(eng_x_data), 0);
    check("rst_y_valid", int'(rq_y_valid), 0);
    check("rst_eng_y_ready", int'(eng_y_ready), 0);
    check("rst_y_data", int'(rq_y_data), 0);
    reset = 1'b0;
    rq_x_valid = '0;
    rq_f_valid = '0;
    eng_y_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) run_job(tbl[i]);

    // Reset in the middle of a load at xcnt=50
    req = 2'b01;
    @(posedge clk);
    @(negedge clk);
    check("t5_grant", int'(gnt), 1);
    rq_x_valid = 2'b11;
    rq_f_valid = 2'b00;
    eng_x_ready = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("t5_loading", int'(eng_x_valid), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_gnt", int'(gnt), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    check("t5_x_ready", int'(rq_x_ready), 0);
    check("t5_eng_x_valid", int'(eng_x_valid), 0);
    check("t5_eng_x_data", int'(eng_x_data), 0);
    reset = 1'b0;
    rq_x_valid = '0;
    run_job(tbl[4]);

    @(negedge clk);
    check("final_done", int'(done), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
